// File: rtl/ctl_pkg.sv
// Shared types and flag bit positions for the CTL carry-in / PC-flag logic.
package ctl_pkg;

  typedef enum logic [1:0] {
    NONE      = 2'd0,
    XCRY_AR0  = 2'd1,
    XCRY_FLAG = 2'd2,
    RSVD      = 2'd3
  } cry_spec_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SAVE      = 2'd1,
    PI_ACTIVE = 2'd2,
    RESTORE   = 2'd3
  } pi_state_t;

  localparam int FLG_OV   = 0;
  localparam int FLG_CRY0 = 1;
  localparam int FLG_CRY1 = 2;
  localparam int FLG_USER = 3;

endpackage

// File: rtl/ctl_pi_seq.sv
// PI-cycle sequencer: IDLE -> SAVE -> PI_ACTIVE -> RESTORE -> IDLE.
// save_en / restore_en are high for the whole of the one-cycle SAVE / RESTORE states.
module ctl_pi_seq
  import ctl_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      pi_start,
  input  logic      pi_dismiss,
  output pi_state_t state,
  output logic      save_en,
  output logic      restore_en
);

  pi_state_t state_q;
  pi_state_t state_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    save_en    = 1'b0;
    restore_en = 1'b0;
    case (state_q)
      IDLE: begin
        if (pi_start) state_d = SAVE;
      end
      SAVE: begin
        save_en = 1'b1;
        state_d = PI_ACTIVE;
      end
      PI_ACTIVE: begin
        if (pi_dismiss) state_d = RESTORE;
      end
      RESTORE: begin
        restore_en = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign state = state_q;

endmodule

// File: rtl/ctl_carry_flags.sv
// ADX carry-36 generation and the PC-flag register with PI save/restore.
// ar uses machine numbering: machine bit i (bit 0 = sign) is ar[WIDTH-1-i].
module ctl_carry_flags
  import ctl_pkg::*;
#(
  parameter int WIDTH  = 36,
  parameter int NFLAGS = 13
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cram_ad_carry,
  input  logic [1:0]        cram_cry_spec,
  input  logic [WIDTH-1:0]  ar,
  input  logic              pc_plus1_inh,
  input  logic              ad_cry0,
  input  logic              ad_cry1,
  input  logic              flags_update,
  input  logic              flags_load,
  input  logic              pi_start,
  input  logic              pi_dismiss,
  output logic              adx_carry36,
  output logic [NFLAGS-1:0] flags,
  output logic [NFLAGS-1:0] saved_flags,
  output logic [1:0]        pi_state
);

  generate
    if (NFLAGS < 4 || NFLAGS > WIDTH) begin : g_bad_nflags
      $error("ctl_carry_flags: NFLAGS must be in 4..WIDTH");
    end
    if (NFLAGS < WIDTH) begin : g_ar_low
      logic unused_ar_low;
      assign unused_ar_low = ^ar[WIDTH-NFLAGS-1:0];
    end
  endgenerate

  pi_state_t         state;
  logic              save_en;
  logic              restore_en;
  cry_spec_t         cry_spec;
  logic              carry_term;
  logic              carry_inh;
  logic [NFLAGS-1:0] flags_q;
  logic [NFLAGS-1:0] flags_d;
  logic [NFLAGS-1:0] saved_flags_q;
  logic [NFLAGS-1:0] saved_flags_d;

  ctl_pi_seq u_pi_seq (
    .clk        (clk),
    .reset      (reset),
    .pi_start   (pi_start),
    .pi_dismiss (pi_dismiss),
    .state      (state),
    .save_en    (save_en),
    .restore_en (restore_en)
  );

  assign cry_spec = cry_spec_t'(cram_cry_spec);

  always_comb begin
    carry_term = 1'b0;
    case (cry_spec)
      XCRY_AR0:  carry_term = ar[WIDTH-1];
      XCRY_FLAG: carry_term = flags_q[FLG_CRY0];
      default:   carry_term = 1'b0;
    endcase
    carry_inh   = (pc_plus1_inh && (cry_spec == XCRY_AR0)) || save_en;
    adx_carry36 = carry_inh ? 1'b0 : (cram_ad_carry ^ carry_term);
  end

  // Later assignments win: update < save USER clear < restore < load.
  always_comb begin
    flags_d       = flags_q;
    saved_flags_d = saved_flags_q;
    if (flags_update) begin
      flags_d[FLG_CRY0] = flags_q[FLG_CRY0] | ad_cry0;
      flags_d[FLG_CRY1] = flags_q[FLG_CRY1] | ad_cry1;
      flags_d[FLG_OV]   = flags_q[FLG_OV] | (ad_cry0 ^ ad_cry1);
    end
    if (save_en) begin
      saved_flags_d     = flags_q;
      flags_d[FLG_USER] = 1'b0;
    end
    if (restore_en) begin
      flags_d = saved_flags_q;
    end
    if (flags_load) begin
      flags_d = ar[WIDTH-1 -: NFLAGS];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q       <= '0;
      saved_flags_q <= '0;
    end else begin
      flags_q       <= flags_d;
      saved_flags_q <= saved_flags_d;
    end
  end

  assign flags       = flags_q;
  assign saved_flags = saved_flags_q;
  assign pi_state    = state;

endmodule

// File: tb/tb_ctl_carry_flags.sv
// Scoreboard bench for ctl_carry_flags: directed vectors push expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_ctl_carry_flags;

  localparam int WIDTH  = 36;
  localparam int NFLAGS = 13;

  logic              clk;
  logic              reset;
  logic              cram_ad_carry;
  logic [1:0]        cram_cry_spec;
  logic [WIDTH-1:0]  ar;
  logic              pc_plus1_inh;
  logic              ad_cry0;
  logic              ad_cry1;
  logic              flags_update;
  logic              flags_load;
  logic              pi_start;
  logic              pi_dismiss;
  logic              adx_carry36;
  logic [NFLAGS-1:0] flags;
  logic [NFLAGS-1:0] saved_flags;
  logic [1:0]        pi_state;

  typedef struct {
    string             name;
    logic              adx;
    logic [NFLAGS-1:0] flg;
    logic [NFLAGS-1:0] sav;
    logic [1:0]        st;
  } exp_t;

  exp_t exp_q[$];
  int   n_compared;
  int   n_mismatched;

  ctl_carry_flags #(.WIDTH(WIDTH), .NFLAGS(NFLAGS)) dut (
    .clk           (clk),
    .reset         (reset),
    .cram_ad_carry (cram_ad_carry),
    .cram_cry_spec (cram_cry_spec),
    .ar            (ar),
    .pc_plus1_inh  (pc_plus1_inh),
    .ad_cry0       (ad_cry0),
    .ad_cry1       (ad_cry1),
    .flags_update  (flags_update),
    .flags_load    (flags_load),
    .pi_start      (pi_start),
    .pi_dismiss    (pi_dismiss),
    .adx_carry36   (adx_carry36),
    .flags         (flags),
    .saved_flags   (saved_flags),
    .pi_state      (pi_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string nm, input string field, input logic [31:0] act,
                     input logic [31:0] req);
    n_compared++;
    if (act !== req) begin
      n_mismatched++;
      $display("[TB] FAIL %s.%s: got 0x%0h, expected 0x%0h", nm, field, act, req);
    end
  endtask

  // Monitor: outputs are stable at the falling edge, between stimulus and the next rising edge.
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      cmp(e.name, "adx_carry36", 32'(adx_carry36), 32'(e.adx));
      cmp(e.name, "flags",       32'(flags),       32'(e.flg));
      cmp(e.name, "saved_flags", 32'(saved_flags), 32'(e.sav));
      cmp(e.name, "pi_state",    32'(pi_state),    32'(e.st));
    end
  end

  // Machine bit 0 of ar is the MSB; load_val lands in machine bits 0..NFLAGS-1.
  task automatic applyStimulus(input logic rst, input logic [1:0] spec, input logic cram,
                               input logic ar0, input logic inh, input logic upd,
                               input logic c0, input logic c1, input logic load,
                               input logic [NFLAGS-1:0] load_val, input logic start,
                               input logic dismiss);
    reset         = rst;
    cram_cry_spec = spec;
    cram_ad_carry = cram;
    ar            = '1;
    ar[WIDTH-1 -: NFLAGS] = load_val;
    ar[WIDTH-1]   = ar[WIDTH-1] | ar0;
    pc_plus1_inh  = inh;
    flags_update  = upd;
    ad_cry0       = c0;
    ad_cry1       = c1;
    flags_load    = load;
    pi_start      = start;
    pi_dismiss    = dismiss;
  endtask

  task automatic checkOutput(input string nm, input logic adx, input logic [NFLAGS-1:0] flg,
                             input logic [NFLAGS-1:0] sav, input logic [1:0] st);
    exp_t e;
    e.name = nm;
    e.adx  = adx;
    e.flg  = flg;
    e.sav  = sav;
    e.st   = st;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;

    //            rst spec cry ar0 inh upd c0 c1 load val       start dis
    applyStimulus(1, 2'd0, 0, 0, 0, 0, 0, 0, 0, 13'h0000, 0, 0);
    tick();

    applyStimulus(0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 13'h0000, 0, 0);
    checkOutput("reset_state", 1'b0, 13'h0000, 13'h0000, 2'd0);
    tick();

    // Carry mux in IDLE
    applyStimulus(0, 2'd1, 0, 1, 0, 0, 0, 0, 0, 13'h0000, 0, 0);
    checkOutput("ar0_cram0", 1'b1, 13'h0000, 13'h0000, 2'd0);
    tick();
    applyStimulus(0, 2'd1, 1, 1, 0, 0, 0, 0, 0, 13'h0000, 0, 0);
    checkOutput("ar0_cram1", 1'b0, 13'h0000, 13'h0000, 2'd0);
    tick();
    applyStimulus(0, 2'd0, 1, 1, 0, 0, 0, 0, 0, 13'h0000, 0, 0);
    checkOutput("none_cram1", 1'b1, 13'h0000, 13'h0000, 2'd0);
    tick();
    applyStimulus(0, 2'd3, 1, 1, 0, 0, 0, 0, 0, 13'h0000, 0, 0);
    checkOutput("rsvd_cram1", 1'b1, 13'h0000, 13'h0000, 2'd0);
    tick();

    // Inhibit
    applyStimulus(0, 2'd1, 1, 1, 1, 0, 0, 0, 0, 13'h0000, 0, 0);
    checkOutput("inh_ar0", 1'b0, 13'h0000, 13'h0000, 2'd0);
    tick();
    applyStimulus(0, 2'd0, 1, 1, 1, 0, 0, 0, 0, 13'h0000, 0, 0);
    checkOutput("inh_none", 1'b1, 13'h0000, 13'h0000, 2'd0);
    tick();

    // Sticky flags
    applyStimulus(0, 2'd0, 0, 0, 0, 1, 1, 0, 0, 13'h0000, 0, 0);
    checkOutput("upd_cry0_pre", 1'b0, 13'h0000, 13'h0000, 2'd0);
    tick();
    applyStimulus(0, 2'd0, 0, 0, 0, 1, 0, 0, 0, 13'h0000, 0, 0);
    checkOutput("upd_cry0_post", 1'b0, 13'h0003, 13'h0000, 2'd0);
    tick();
    applyStimulus(0, 2'd2, 0, 0, 0, 0, 0, 0, 0, 13'h0000, 0, 0);
    checkOutput("sticky_flagcry", 1'b1, 13'h0003, 13'h0000, 2'd0);
    tick();
    applyStimulus(0, 2'd2, 1, 0, 0, 1, 0, 1, 0, 13'h0000, 0, 0);
    checkOutput("flagcry_cram1", 1'b0, 13'h0003, 13'h0000, 2'd0);
    tick();
    applyStimulus(0, 2'd0, 0, 0, 0, 0, 0, 0, 1, 13'h0008, 0, 0);
    checkOutput("upd_cry1", 1'b0, 13'h0007, 13'h0000, 2'd0);
    tick();

    // PI round trip with USER set and an update during SAVE
    applyStimulus(0, 2'd0, 1, 0, 0, 0, 0, 0, 0, 13'h0000, 1, 0);
    checkOutput("loaded_user", 1'b1, 13'h0008, 13'h0000, 2'd0);
    tick();
    applyStimulus(0, 2'd0, 1, 0, 0, 1, 1, 1, 0, 13'h0000, 0, 0);
    checkOutput("save_state", 1'b0, 13'h0008, 13'h0000, 2'd1);
    tick();
    applyStimulus(0, 2'd0, 1, 0, 0, 0, 0, 0, 0, 13'h0000, 1, 0);
    checkOutput("pi_active", 1'b1, 13'h0006, 13'h0008, 2'd2);
    tick();
    applyStimulus(0, 2'd0, 1, 0, 0, 0, 0, 0, 0, 13'h0000, 0, 1);
    checkOutput("start_ignored", 1'b1, 13'h0006, 13'h0008, 2'd2);
    tick();
    applyStimulus(0, 2'd0, 1, 0, 0, 0, 0, 0, 0, 13'h0000, 0, 0);
    checkOutput("restore_state", 1'b1, 13'h0006, 13'h0008, 2'd3);
    tick();
    applyStimulus(0, 2'd0, 0, 0, 0, 1, 1, 0, 0, 13'h0000, 1, 1);
    checkOutput("restored", 1'b0, 13'h0008, 13'h0008, 2'd0);
    tick();

    // Second trip: load during SAVE and during RESTORE
    applyStimulus(0, 2'd0, 0, 0, 0, 0, 0, 0, 1, 13'h0A5A, 0, 0);
    checkOutput("save2", 1'b0, 13'h000B, 13'h0008, 2'd1);
    tick();
    applyStimulus(0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 13'h0000, 0, 1);
    checkOutput("load_in_save", 1'b0, 13'h0A5A, 13'h000B, 2'd2);
    tick();
    applyStimulus(0, 2'd0, 0, 0, 0, 0, 0, 0, 1, 13'h1FFF, 0, 0);
    checkOutput("restore2", 1'b0, 13'h0A5A, 13'h000B, 2'd3);
    tick();
    applyStimulus(0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 13'h0000, 1, 0);
    checkOutput("load_in_restore", 1'b0, 13'h1FFF, 13'h000B, 2'd0);
    tick();
    applyStimulus(0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 13'h0000, 0, 0);
    checkOutput("save3", 1'b0, 13'h1FFF, 13'h000B, 2'd1);
    tick();

    // Reset in PI_ACTIVE beats a simultaneous load
    applyStimulus(1, 2'd0, 0, 0, 0, 0, 0, 0, 1, 13'h1FFF, 0, 0);
    checkOutput("pi_active3", 1'b0, 13'h1FF7, 13'h1FFF, 2'd2);
    tick();
    applyStimulus(0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 13'h0000, 0, 1);
    checkOutput("mid_reset", 1'b0, 13'h0000, 13'h0000, 2'd0);
    tick();
    applyStimulus(0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 13'h0000, 0, 0);
    checkOutput("dismiss_ignored", 1'b0, 13'h0000, 13'h0000, 2'd0);
    tick();

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_compared++;
      n_mismatched++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
